// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding and load-use bubble insertion.
// Optional macro ID_EX_PERF_EN adds saturating bubble/hold performance counters.
module id_ex_operand_stage #(
  parameter int WIDTH   = 8,
  parameter int REGBITS = 3,
  parameter int CTRLW   = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               id_valid,
  input  logic [REGBITS-1:0] id_rs,
  input  logic [REGBITS-1:0] id_rt,
  input  logic [WIDTH-1:0]   id_rs_data,
  input  logic [WIDTH-1:0]   id_rt_data,
  input  logic [WIDTH-1:0]   id_imm,
  input  logic               id_alusrc,
  input  logic [CTRLW-1:0]   id_alucontrol,
  input  logic [REGBITS-1:0] id_dst,
  input  logic               id_regwrite,
  input  logic               id_memtoreg,
  input  logic               ex_stall,
  input  logic               flush,
  input  logic               mem_regwrite,
  input  logic [REGBITS-1:0] mem_dst,
  input  logic [WIDTH-1:0]   mem_result,
  input  logic               wb_regwrite,
  input  logic [REGBITS-1:0] wb_dst,
  input  logic [WIDTH-1:0]   wb_result,
  output logic               id_stall,
  output logic               ex_valid,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic [WIDTH-1:0]   ex_store_data,
  output logic [CTRLW-1:0]   ex_alucontrol,
  output logic [REGBITS-1:0] ex_dst,
  output logic               ex_regwrite,
  output logic               ex_memtoreg
`ifdef ID_EX_PERF_EN
  ,
  output logic [15:0]        perf_bubbles,
  output logic [15:0]        perf_holds
`endif
);

  logic [REGBITS-1:0] rs_idx_r;
  logic [REGBITS-1:0] rt_idx_r;
  logic [WIDTH-1:0]   rs_val_r;
  logic [WIDTH-1:0]   rt_val_r;
  logic [WIDTH-1:0]   imm_r;
  logic               alusrc_r;
  logic [WIDTH-1:0]   fwd_rs_s;
  logic [WIDTH-1:0]   fwd_rt_s;
  logic               load_use_s;

  // r0 is forced to zero; the younger EX/MEM result beats MEM/WB.
  function automatic logic [WIDTH-1:0] fwd_sel(
    input logic [REGBITS-1:0] src,
    input logic [WIDTH-1:0]   reg_val,
    input logic               m_we,
    input logic [REGBITS-1:0] m_dst,
    input logic [WIDTH-1:0]   m_res,
    input logic               w_we,
    input logic [REGBITS-1:0] w_dst,
    input logic [WIDTH-1:0]   w_res
  );
    logic [WIDTH-1:0] val;
    if (src == {REGBITS{1'b0}}) begin
      val = {WIDTH{1'b0}};
    end else if (m_we && (m_dst == src)) begin
      val = m_res;
    end else if (w_we && (w_dst == src)) begin
      val = w_res;
    end else begin
      val = reg_val;
    end
    return val;
  endfunction

  assign fwd_rs_s = fwd_sel(rs_idx_r, rs_val_r, mem_regwrite, mem_dst, mem_result,
                            wb_regwrite, wb_dst, wb_result);
  assign fwd_rt_s = fwd_sel(rt_idx_r, rt_val_r, mem_regwrite, mem_dst, mem_result,
                            wb_regwrite, wb_dst, wb_result);

  assign alu_a         = fwd_rs_s;
  assign alu_b         = alusrc_r ? imm_r : fwd_rt_s;
  assign ex_store_data = fwd_rt_s;

  // rt only matters for the hazard when the instruction actually reads it as an operand.
  assign load_use_s = ex_valid & ex_memtoreg & (ex_dst != {REGBITS{1'b0}}) & id_valid &
                      ((ex_dst == id_rs) | ((ex_dst == id_rt) & ~id_alusrc));
  assign id_stall   = ex_stall | load_use_s;

  // EX slot update: flush, then hold (with operand refresh), then bubble, then load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid      <= 1'b0;
      rs_idx_r      <= {REGBITS{1'b0}};
      rt_idx_r      <= {REGBITS{1'b0}};
      rs_val_r      <= {WIDTH{1'b0}};
      rt_val_r      <= {WIDTH{1'b0}};
      imm_r         <= {WIDTH{1'b0}};
      alusrc_r      <= 1'b0;
      ex_alucontrol <= {CTRLW{1'b0}};
      ex_dst        <= {REGBITS{1'b0}};
      ex_regwrite   <= 1'b0;
      ex_memtoreg   <= 1'b0;
    end else if (flush) begin
      ex_valid    <= 1'b0;
      ex_regwrite <= 1'b0;
      ex_memtoreg <= 1'b0;
    end else if (ex_stall) begin
      rs_val_r <= fwd_rs_s;
      rt_val_r <= fwd_rt_s;
    end else if (load_use_s) begin
      ex_valid    <= 1'b0;
      ex_regwrite <= 1'b0;
      ex_memtoreg <= 1'b0;
    end else begin
      ex_valid      <= id_valid;
      rs_idx_r      <= id_rs;
      rt_idx_r      <= id_rt;
      rs_val_r      <= id_rs_data;
      rt_val_r      <= id_rt_data;
      imm_r         <= id_imm;
      alusrc_r      <= id_alusrc;
      ex_alucontrol <= id_alucontrol;
      ex_dst        <= id_dst;
      ex_regwrite   <= id_valid & id_regwrite;
      ex_memtoreg   <= id_valid & id_memtoreg;
    end
  end

`ifdef ID_EX_PERF_EN
  // Saturating counters; a flush suppresses both the hold and the bubble it overrides.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_bubbles <= 16'h0000;
      perf_holds   <= 16'h0000;
    end else begin
      if (!flush && ex_stall && (perf_holds != 16'hFFFF)) begin
        perf_holds <= perf_holds + 16'h0001;
      end else begin
        perf_holds <= perf_holds;
      end
      if (!flush && !ex_stall && load_use_s && (perf_bubbles != 16'hFFFF)) begin
        perf_bubbles <= perf_bubbles + 16'h0001;
      end else begin
        perf_bubbles <= perf_bubbles;
      end
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed self-checking bench for id_ex_operand_stage: reset, forwarding, r0, load-use, hold refresh, flush.
module tb_id_ex_operand_stage;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid;
  logic [2:0] id_rs, id_rt, id_dst;
  logic [7:0] id_rs_data, id_rt_data, id_imm;
  logic       id_alusrc, id_regwrite, id_memtoreg;
  logic [2:0] id_alucontrol;
  logic       ex_stall, flush;
  logic       mem_regwrite, wb_regwrite;
  logic [2:0] mem_dst, wb_dst;
  logic [7:0] mem_result, wb_result;
  logic       id_stall, ex_valid, ex_regwrite, ex_memtoreg;
  logic [7:0] alu_a, alu_b, ex_store_data;
  logic [2:0] ex_alucontrol, ex_dst;
`ifdef ID_EX_PERF_EN
  logic [15:0] perf_bubbles, perf_holds;
`endif
  int checks = 0;
  int errors = 0;

  id_ex_operand_stage dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_alusrc(id_alusrc), .id_alucontrol(id_alucontrol), .id_dst(id_dst),
    .id_regwrite(id_regwrite), .id_memtoreg(id_memtoreg), .ex_stall(ex_stall),
    .flush(flush), .mem_regwrite(mem_regwrite), .mem_dst(mem_dst),
    .mem_result(mem_result), .wb_regwrite(wb_regwrite), .wb_dst(wb_dst),
    .wb_result(wb_result), .id_stall(id_stall), .ex_valid(ex_valid),
    .alu_a(alu_a), .alu_b(alu_b), .ex_store_data(ex_store_data),
    .ex_alucontrol(ex_alucontrol), .ex_dst(ex_dst), .ex_regwrite(ex_regwrite),
    .ex_memtoreg(ex_memtoreg)
`ifdef ID_EX_PERF_EN
    , .perf_bubbles(perf_bubbles), .perf_holds(perf_holds)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [2:0] rs, input logic [2:0] rt,
                        input logic [7:0] rsd, input logic [7:0] rtd, input logic [7:0] imm,
                        input logic asrc, input logic [2:0] ctl, input logic [2:0] dst,
                        input logic rw, input logic m2r);
    id_valid = v; id_rs = rs; id_rt = rt; id_rs_data = rsd; id_rt_data = rtd;
    id_imm = imm; id_alusrc = asrc; id_alucontrol = ctl; id_dst = dst;
    id_regwrite = rw; id_memtoreg = m2r;
  endtask

  initial begin
    rst_n = 1'b0; ex_stall = 1'b0; flush = 1'b0;
    mem_regwrite = 1'b0; mem_dst = 3'd0; mem_result = 8'h00;
    wb_regwrite = 1'b0; wb_dst = 3'd0; wb_result = 8'h00;
    set_id(1'b0, 3'd0, 3'd0, 8'h00, 8'h00, 8'h00, 1'b0, 3'b000, 3'd0, 1'b0, 1'b0);
    #12;
    check("rst_valid", {15'd0, ex_valid}, 16'h0000);
    check("rst_a", {8'd0, alu_a}, 16'h0000);
    check("rst_b", {8'd0, alu_b}, 16'h0000);
    check("rst_ctl", {13'd0, ex_alucontrol}, 16'h0000);
    @(negedge clk); rst_n = 1'b1;

    // Basic load, one-cycle latency, alusrc selection
    set_id(1'b1, 3'd1, 3'd2, 8'h12, 8'h34, 8'h56, 1'b0, 3'b010, 3'd5, 1'b1, 1'b0);
    tick();
    check("ld_valid", {15'd0, ex_valid}, 16'h0001);
    check("ld_a", {8'd0, alu_a}, 16'h0012);
    check("ld_b_rt", {8'd0, alu_b}, 16'h0034);
    check("ld_ctl", {13'd0, ex_alucontrol}, 16'h0002);
    check("ld_dst", {13'd0, ex_dst}, 16'h0005);
    check("ld_rw", {15'd0, ex_regwrite}, 16'h0001);
    id_alusrc = 1'b1;
    tick();
    check("ld_b_imm", {8'd0, alu_b}, 16'h0056);
    check("ld_store", {8'd0, ex_store_data}, 16'h0034);

    // EX/MEM beats MEM/WB, then WB, then register
    set_id(1'b1, 3'd2, 3'd1, 8'h01, 8'h02, 8'h00, 1'b0, 3'b000, 3'd6, 1'b1, 1'b0);
    tick();
    mem_regwrite = 1'b1; mem_dst = 3'd2; mem_result = 8'h5A;
    wb_regwrite = 1'b1; wb_dst = 3'd2; wb_result = 8'h11;
    #1 check("fwd_mem", {8'd0, alu_a}, 16'h005A);
    mem_regwrite = 1'b0;
    #1 check("fwd_wb", {8'd0, alu_a}, 16'h0011);
    wb_regwrite = 1'b0;
    #1 check("fwd_none", {8'd0, alu_a}, 16'h0001);

    // r0 never forwarded and forced zero
    set_id(1'b1, 3'd0, 3'd1, 8'h33, 8'h02, 8'h00, 1'b0, 3'b000, 3'd6, 1'b1, 1'b0);
    tick();
    mem_regwrite = 1'b1; mem_dst = 3'd0; mem_result = 8'hFF;
    #1 check("r0_zero", {8'd0, alu_a}, 16'h0000);
    mem_regwrite = 1'b0;

    // Asynchronous reset mid-run
    set_id(1'b1, 3'd1, 3'd2, 8'h77, 8'h44, 8'h00, 1'b0, 3'b001, 3'd4, 1'b1, 1'b0);
    tick();
    check("pre_rst_a", {8'd0, alu_a}, 16'h0077);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", {15'd0, ex_valid}, 16'h0000);
    check("arst_a", {8'd0, alu_a}, 16'h0000);
    check("arst_b", {8'd0, alu_b}, 16'h0000);
    @(negedge clk); rst_n = 1'b1;

    // Load-use: lw r3 in EX, add reads r3
    set_id(1'b1, 3'd1, 3'd0, 8'h10, 8'h00, 8'h04, 1'b1, 3'b010, 3'd3, 1'b1, 1'b1);
    tick();
    check("lw_m2r", {15'd0, ex_memtoreg}, 16'h0001);
    set_id(1'b1, 3'd3, 3'd1, 8'h00, 8'h20, 8'h00, 1'b0, 3'b010, 3'd6, 1'b1, 1'b0);
    #1 check("lu_stall", {15'd0, id_stall}, 16'h0001);
    tick();
    check("lu_bubble", {15'd0, ex_valid}, 16'h0000);
    check("lu_rw", {15'd0, ex_regwrite}, 16'h0000);
    check("lu_m2r", {15'd0, ex_memtoreg}, 16'h0000);
    check("lu_release", {15'd0, id_stall}, 16'h0000);
    tick();
    check("lu_add_valid", {15'd0, ex_valid}, 16'h0001);
    check("lu_add_dst", {13'd0, ex_dst}, 16'h0006);
    set_id(1'b1, 3'd1, 3'd0, 8'h10, 8'h00, 8'h04, 1'b1, 3'b010, 3'd3, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 3'd1, 3'd3, 8'h00, 8'h00, 8'h08, 1'b1, 3'b010, 3'd6, 1'b1, 1'b0);
    #1 check("lu_rt_imm", {15'd0, id_stall}, 16'h0000);
    id_alusrc = 1'b0;
    #1 check("lu_rt_reg", {15'd0, id_stall}, 16'h0001);
    id_valid = 1'b0;
    #1 check("lu_id_inv", {15'd0, id_stall}, 16'h0000);
    tick();
    check("inv_valid", {15'd0, ex_valid}, 16'h0000);
    check("inv_rw", {15'd0, ex_regwrite}, 16'h0000);
`ifdef ID_EX_PERF_EN
    check("perf_bubbles", perf_bubbles, 16'h0001);
`endif

    // Hold refresh: WB retires r4 during a two-cycle stall
    set_id(1'b1, 3'd1, 3'd4, 8'h01, 8'h00, 8'h00, 1'b0, 3'b001, 3'd2, 1'b1, 1'b0);
    tick();
    ex_stall = 1'b1; wb_regwrite = 1'b1; wb_dst = 3'd4; wb_result = 8'h7C;
    #1 check("hold_fwd", {8'd0, alu_b}, 16'h007C);
    check("hold_stall", {15'd0, id_stall}, 16'h0001);
    tick();
    wb_regwrite = 1'b0; id_rt_data = 8'h99; id_dst = 3'd5;
    #1 check("hold_refresh", {8'd0, alu_b}, 16'h007C);
    check("hold_dst", {13'd0, ex_dst}, 16'h0002);
    tick();
    check("hold2_b", {8'd0, alu_b}, 16'h007C);
    check("hold2_valid", {15'd0, ex_valid}, 16'h0001);
`ifdef ID_EX_PERF_EN
    check("perf_holds", perf_holds, 16'h0002);
`endif

    // Flush and stall on the same edge
    flush = 1'b1;
    tick();
    check("flush_valid", {15'd0, ex_valid}, 16'h0000);
    check("flush_rw", {15'd0, ex_regwrite}, 16'h0000);
`ifdef ID_EX_PERF_EN
    check("flush_holds", perf_holds, 16'h0002);
`endif
    flush = 1'b0; ex_stall = 1'b0;
    tick();
    check("post_valid", {15'd0, ex_valid}, 16'h0001);
    check("post_dst", {13'd0, ex_dst}, 16'h0005);
    check("post_b", {8'd0, alu_b}, 16'h0099);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
